// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//
// Polyphonic note scheduler sitting between song_reader and a bank of
// note_player voices. Note entries are loaded into the lowest-index free
// voice; rest entries (note code 0) hold the reader for `duration` beats.
// Each entry is acknowledged with a one-cycle note_done pulse, so a chord is
// a run of notes followed by a rest.
//
// Optional feature macro: VOICE_STEAL_EN
//   defined     : with every voice busy, the voice with the largest age is
//                 reloaded (ties go to the lowest index); STALL is unreachable.
//   not defined : with every voice busy, the reader is held in STALL until
//                 a voice reports done.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-low reset
//   play           in   enables beat counting during rests
//   beat           in   one-cycle beat pulse
//   new_note       in   one-cycle entry strobe from the reader
//   note           in   entry note code, 0 = rest
//   duration       in   entry length in beats
//   note_done      out  one-cycle ack to the reader
//   voice_load     out  one-hot load pulse to the selected voice
//   voice_note     out  registered note bus shared by all voices
//   voice_duration out  registered duration bus shared by all voices
//   voice_done     in   per-voice note_done pulses
//   voice_busy     out  per-voice busy flags
//   overrun        out  sticky; new_note arrived outside IDLE
// ---------------------------------------------------------------------------
module voice_allocator #(
  parameter int VOICES = 3,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              beat,
  input  logic              new_note,
  input  logic [NOTE_W-1:0] note,
  input  logic [DUR_W-1:0]  duration,
  output logic              note_done,
  output logic [VOICES-1:0] voice_load,
  output logic [NOTE_W-1:0] voice_note,
  output logic [DUR_W-1:0]  voice_duration,
  input  logic [VOICES-1:0] voice_done,
  output logic [VOICES-1:0] voice_busy,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STALL,
    S_REST,
    S_ACK
  } state_t;

  localparam logic [3:0] AGE_MAX = 4'hF;

  state_t            state;
  state_t            state_next;
  logic [VOICES-1:0] busy;
  logic [3:0]        age [VOICES];
  logic [DUR_W-1:0]  rest_cnt;
  logic [DUR_W-1:0]  rest_inc;
  logic              beat_hit;
  logic [VOICES-1:0] target_vec;
  logic              target_ok;

  assign voice_busy = busy;
  assign rest_inc   = rest_cnt + DUR_W'(1);
  assign beat_hit   = beat && play;

  // Target selection: lowest-index free voice, or (with stealing) the oldest.
  always_comb begin
    // NOTE: every variable written here gets a default before any branch,
    // and blocking '=' is used so the loop sees its own earlier iterations;
    // this keeps the block purely combinational with no inferred latches.
    target_vec = '0;
    target_ok  = 1'b0;
    for (int i = 0; i < VOICES; i++) begin
      if (!target_ok && !busy[i]) begin
        target_vec[i] = 1'b1;
        target_ok     = 1'b1;
      end
    end
`ifdef VOICE_STEAL_EN
    if (!target_ok) begin
      int unsigned best;
      best = 0;
      // Strict '>' keeps the lowest index on equal ages.
      for (int i = 1; i < VOICES; i++) begin
        if (age[i] > age[best]) best = i;
      end
      target_vec[best] = 1'b1;
      target_ok        = 1'b1;
    end
`endif
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_next = state;
    voice_load = '0;
    note_done  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (new_note) state_next = (note == '0) ? S_REST : S_LOAD;
      end
      S_LOAD: begin
        if (target_ok) begin
          voice_load = target_vec;
          state_next = S_ACK;
        end else begin
          state_next = S_STALL;
        end
      end
      S_STALL: begin
        if (busy != '1) state_next = S_LOAD;
      end
      S_REST: begin
        // Leave on the beat that reaches the target count, so the ack
        // lands one cycle after that beat; duration 0 leaves at once.
        if (rest_cnt == voice_duration) begin
          state_next = S_ACK;
        end else if (beat_hit && rest_inc == voice_duration) begin
          state_next = S_ACK;
        end
      end
      S_ACK: begin
        note_done  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      busy           <= '0;
      rest_cnt       <= '0;
      voice_note     <= '0;
      voice_duration <= '0;
      overrun        <= 1'b0;
      // NOTE: the age table is only VOICES nibbles and must start at zero
      // for a deterministic steal order, so it is reset like plain flops.
      for (int i = 0; i < VOICES; i++) age[i] <= '0;
    end else begin
      state <= state_next;

      // A load in the same cycle as a done on that voice keeps it busy.
      busy <= (busy & ~voice_done) | voice_load;

      if (new_note && state != S_IDLE) overrun <= 1'b1;

      if (state == S_IDLE) begin
        rest_cnt <= '0;
        if (new_note) begin
          voice_note     <= note;
          voice_duration <= duration;
        end
      end

      if (state == S_REST && beat_hit && rest_cnt != voice_duration) begin
        rest_cnt <= rest_inc;
      end

      if (|voice_load) begin
        for (int i = 0; i < VOICES; i++) begin
          if (voice_load[i])         age[i] <= '0;
          else if (age[i] != AGE_MAX) age[i] <= age[i] + 4'd1;
        end
      end
    end
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic note scheduler between `song_reader` and a bank of `note_player` voices. It accepts note entries from the reader, assigns each to a free voice, and handles rest entries (note code 0) that advance song time by counting beats. It returns `note_done` to the reader so chords are built from consecutive notes followed by a rest. It owns voice busy tracking and, optionally, voice stealing.

## Interface
- `VOICES`, 3: number of `note_player` instances; legal range 2–4.
- `NOTE_W`, 6: note code width.
- `DUR_W`, 6: duration width, in beats.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low; clears all state.
- `play` in 1: beat counting is enabled only while high.
- `beat` in 1: one-cycle beat pulse.
- `new_note` in 1: one-cycle entry strobe from the reader.
- `note` in NOTE_W: entry note code; 0 means rest.
- `duration` in DUR_W: entry length in beats.
- `note_done` out 1: one-cycle ack; the reader may issue the next entry.
- `voice_load` out VOICES: one-hot load pulse to the selected voice.
- `voice_note` out NOTE_W: shared note bus to the voices; registered.
- `voice_duration` out DUR_W: shared duration bus to the voices; registered.
- `voice_done` in VOICES: per-voice `note_done` pulses.
- `voice_busy` out VOICES: per-voice busy flags.
- `overrun` out 1: sticky; set when `new_note` arrives outside IDLE.

## Operation
- **States:** IDLE, LOAD, STALL, REST, ACK.
- **IDLE:**
  - On `new_note`, capture `note` and `duration` into `voice_note` and `voice_duration`.
  - Go to REST if note == 0, else go to LOAD.
- **LOAD:**
  - Target = lowest-index voice with busy == 0.
  - If a target exists: drive `voice_load[target]` = 1 for this cycle only, set `busy[target]`, reset `age[target]` to 0, increment every other voice's age (saturating at 2^4−1), then go to ACK.
  - If all voices are busy, see Configuration.
- **STALL:** no load is issued. Go to LOAD on the first cycle in which `voice_busy` is not all-ones.
- **REST:**
  - A DUR_W-bit counter, cleared on entry, increments on `beat && play`.
  - Go to ACK when count == duration. Duration 0 goes to ACK immediately.
- **ACK:** `note_done` = 1 for one cycle, then go to IDLE.
- **Busy tracking:**
  - `busy[i]` clears on `voice_done[i]`.
  - If load and done hit the same voice in the same cycle, load wins and busy stays 1.
  - `voice_done` on an idle voice is ignored.
- **Input rules:**
  - `new_note` outside IDLE is dropped and sets `overrun`. Only reset clears `overrun`.
  - `play` low freezes the REST counter only; LOAD, STALL and ACK still progress.
- **Reset values:** state = IDLE, `voice_busy` = 0, all ages = 0, `voice_load` = 0, `note_done` = 0, `voice_note` = 0, `voice_duration` = 0, `overrun` = 0, REST counter = 0.

## Timing
- **Note entry:** `new_note` at cycle t; `voice_load` at t+1; `note_done` at t+2.
- **Rest, duration 0:** `note_done` at t+2.
- **Rest, duration D > 0:** `note_done` one cycle after the D-th qualifying beat.
- **Stall release:** `voice_done` at cycle s clears busy at s+1; STALL sees a free voice at s+1; LOAD at s+2; `note_done` at s+3.
- **Minimum spacing:** back-to-back note entries are at least 3 cycles apart (IDLE, LOAD, ACK).
- **Beat during ACK or IDLE:** not counted.

## Configuration
- **`VOICE_STEAL_EN` defined:**
  - In LOAD with all voices busy, target = voice with the largest age; ties go to the lowest index.
  - The load is issued immediately and busy stays 1. The `note_player` reload overrides the note that was playing.
  - STALL is unreachable.
- **`VOICE_STEAL_EN` not defined:** LOAD with all voices busy goes to STALL and holds the reader, with no ack, until a voice frees.

## Test plan
- **Single note:** reset, then `new_note` with note = 12, duration = 4 -> `voice_load` = 3'b001, `voice_note` = 12, `voice_duration` = 4 at t+1; `note_done` at t+2; `voice_busy` = 3'b001.
- **Chord then rest:** notes 12, 16, 19, then a rest with duration 2 -> loads go to 001, 010, 100 in order; `note_done` after each note; the rest acks one cycle after the 2nd beat; `beat` pulses while `play` = 0 are not counted.
- **Stall, steal disabled:** all three voices busy, then note 20 -> no load and no ack; pulse `voice_done` = 3'b010 at s -> `voice_load` = 3'b010 at s+2, `note_done` at s+3.
- **Steal enabled:** loads 001, 010, 100, then note 24 -> `voice_load` = 3'b001 (oldest) at t+1; the next note steals 3'b010.
- **Simultaneous load and done:** `voice_done[0]` in the LOAD cycle that targets voice 0 -> `voice_busy[0]` stays 1.
- **Overrun and reset:**
  - `new_note` during REST -> `overrun` = 1 and stays set.
  - Drop `reset` mid-REST -> all outputs are 0 immediately; after reset deasserts, the next `new_note` is handled from IDLE.
